uart_frame_packer: RTL and testbench
====================================

# uart_frame_packer

Assembles the byte stream from the UART receiver into 72-bit command frames for the AXI-Lite UART master. It sits between the UART RX byte output (8-bit AXI-Stream) and the master's 72-bit command AXI-Stream input. It also provides an inter-byte timeout that discards partial frames, so the host link resynchronises after a dropped or corrupted byte.

## Interface
Parameters:
- FRAME_BYTES, 9: bytes per frame; the frame width is 8*FRAME_BYTES, which is 72 by default.
- TIMEOUT_CYCLES, 100000: number of idle aclk cycles allowed inside a partial frame before it is discarded; must be ≥ 2.

Ports:
- aclk  in  1  clock.
- areset  in  1  reset; asynchronous, active-high.
- s_axis_tdata  in  8  RX byte.
- s_axis_tvalid  in  1  RX byte valid.
- s_axis_tready  out  1  packer can accept a byte.
- m_axis_tdata  out  8*FRAME_BYTES  assembled frame.
- m_axis_tvalid  out  1  frame valid.
- m_axis_tready  in  1  downstream accepts the frame.
- timeout_err  out  1  one-cycle pulse when a partial frame is discarded.
- drop_cnt  out  16  saturating count of discarded partial frames.

## Operation
- Frame byte order is MSB first. The first accepted byte lands in the top byte of the frame, bits [71:64], and the last byte lands in [7:0]. With the default width this gives: bit 71 = write flag, [63:32] = write data, [31:0] = address.
- The block has two states, COLLECT and OUTPUT.
- s_axis_tready = 1 exactly when the state is COLLECT. It is decoded from the registered state only and never depends on s_axis_tvalid.

COLLECT:
- A byte is accepted on each cycle where s_axis_tvalid & s_axis_tready. On acceptance, shreg <= {shreg[8*FRAME_BYTES-9:0], byte} and byte_cnt increments.
- When the accepted byte is the FRAME_BYTES-th, the following happen together:
  - m_axis_tdata <= the completed frame (the shifted value including this byte);
  - m_axis_tvalid <= 1;
  - byte_cnt <= 0;
  - the state goes to OUTPUT.

OUTPUT:
- m_axis_tdata and m_axis_tvalid are held stable until m_axis_tvalid & m_axis_tready.
- On that handshake: m_axis_tvalid <= 0, m_axis_tdata <= 0, and the state goes to COLLECT.

Timeout (COLLECT state only):
- While byte_cnt = 0, the idle timer is held at 0.
- While byte_cnt > 0 and no byte is accepted, the timer increments each cycle.
- Accepting a byte resets the timer to 0.
- When the timer reaches TIMEOUT_CYCLES-1 with no byte accepted in that cycle, the following happen together:
  - byte_cnt <= 0 and shreg <= 0;
  - the timer clears;
  - timeout_err pulses for one cycle (on the next clock edge);
  - drop_cnt increments, saturating at 16'hFFFF.
- If a byte is accepted in the same cycle the timer expires, the acceptance wins: the byte is stored, the timer restarts, and no drop is recorded.
- In OUTPUT the timer is held at 0 and no timeout is possible.

## Timing
- Reset values of outputs:
  - s_axis_tready = 1 (state COLLECT);
  - m_axis_tdata = 0;
  - m_axis_tvalid = 0;
  - timeout_err = 0;
  - drop_cnt = 0.
- Reset values of internal state: shreg = 0, byte_cnt = 0, timer = 0.
- Reset mid-frame or mid-output discards everything immediately, with no output handshake completed. drop_cnt is not incremented for a reset.
- Latency: m_axis_tvalid rises on the clock edge that accepts the last byte, so it is visible in the cycle after the last-byte handshake.
- s_axis_tready is 0 from the cycle after the last byte until the cycle after the output handshake. It is therefore 0 for at least 1 cycle per frame.
- Maximum throughput: one frame per FRAME_BYTES+1 cycles, reached with back-to-back bytes and m_axis_tready held at 1.
- If the downstream stalls, no bytes are accepted and none are lost. Backpressure reaches the byte source through s_axis_tready.
- timeout_err is high for exactly one cycle per discarded frame.

## Test plan
- Nominal frame: send bytes 0x80,0x11,0x22,0x33,0x44,0xDE,0xAD,0xBE,0xEF back-to-back with m_axis_tready = 1 → m_axis_tdata = 72'h80_11223344_DEADBEEF; m_axis_tvalid high for 1 cycle; s_axis_tready low for exactly 1 cycle.
- Downstream stall: complete one frame with m_axis_tready = 0 for 20 cycles while s_axis_tvalid stays 1 → tdata is stable and tvalid is held; s_axis_tready = 0 throughout; the next byte is accepted only after the handshake and becomes byte 0 of the next frame.
- Timeout: with TIMEOUT_CYCLES = 16, send 4 bytes, then go idle for 20 cycles, then send a full 9-byte frame → a single timeout_err pulse; drop_cnt = 1; the emitted frame contains only the 9 new bytes.
- Expiry race: with TIMEOUT_CYCLES = 16, send 1 byte, then present the next byte exactly when the timer reaches 15 → no timeout_err; drop_cnt = 0; the frame completes normally.
- Reset mid-frame: send 5 bytes, assert areset asynchronously between clock edges, release it, then send 9 bytes → outputs return to their reset values immediately; exactly one frame is emitted with the new 9 bytes; drop_cnt = 0.
- Saturation: force 65536 timeouts, for example with TIMEOUT_CYCLES = 2 and single stray bytes → drop_cnt stays at 16'hFFFF, and timeout_err still pulses on every discard.

Source files
------------

// File: rtl/uart_frame_packer.sv
// uart_frame_packer
// Collects bytes from the UART receiver stream into FRAME_BYTES-wide command
// frames, MSB first, and hands each frame to the command stream. An idle
// timer discards partial frames so the host link resynchronises after a lost
// or corrupted byte. FRAME_BYTES must be at least 2.
module uart_frame_packer #(
  parameter int FRAME_BYTES    = 9,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [8*FRAME_BYTES-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     timeout_err,
  output logic [15:0]              drop_cnt
);

  localparam int FW = 8 * FRAME_BYTES;
  localparam int CW = $clog2(FRAME_BYTES + 1);
  // The timer never exceeds TIMEOUT_CYCLES-1, which always fits in clog2 bits.
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_BYTE = CW'(FRAME_BYTES - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_OUTPUT  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [FW-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [FW-1:0]   tdata_q, tdata_d;
  logic            tvalid_q, tvalid_d;
  logic            terr_q, terr_d;
  logic [15:0]     drop_q, drop_d;
  logic [FW-1:0]   shifted_s;

  // The shift register value after appending the byte on the input.
  assign shifted_s = {shreg_q[FW-9:0], s_axis_tdata};

  // Next-state logic: byte collection, frame hand-off and idle timeout.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    timer_d    = timer_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    terr_d     = 1'b0;
    drop_d     = drop_q;

    case (state_q)
      ST_COLLECT: begin
        if (s_axis_tvalid) begin
          // An accepted byte always restarts the timer, even on the expiry cycle.
          timer_d = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            tdata_d    = shifted_s;
            tvalid_d   = 1'b1;
            byte_cnt_d = '0;
            shreg_d    = '0;
            state_d    = ST_OUTPUT;
          end else begin
            shreg_d    = shifted_s;
            byte_cnt_d = byte_cnt_q + CW'(1);
          end
        end else if (byte_cnt_q != '0) begin
          if (timer_q == TIMER_MAX) begin
            // Partial frame went stale: throw it away and record the drop.
            byte_cnt_d = '0;
            shreg_d    = '0;
            timer_d    = '0;
            terr_d     = 1'b1;
            drop_d     = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end else begin
          timer_d = '0;
        end
      end
      ST_OUTPUT: begin
        timer_d = '0;
        if (m_axis_tready) begin
          tvalid_d = 1'b0;
          tdata_d  = '0;
          state_d  = ST_COLLECT;
        end else begin
          state_d  = ST_OUTPUT;
        end
      end
      default: begin
        state_d    = ST_COLLECT;
        shreg_d    = '0;
        byte_cnt_d = '0;
        timer_d    = '0;
        tdata_d    = '0;
        tvalid_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_COLLECT;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      timer_q    <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      terr_q     <= 1'b0;
      drop_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      timer_q    <= timer_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      terr_q     <= terr_d;
      drop_q     <= drop_d;
    end
  end

  // Ready is a pure decode of the state register, independent of tvalid.
  assign s_axis_tready = (state_q == ST_COLLECT);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign timeout_err   = terr_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Testbench for uart_frame_packer: directed and randomized byte streams
// checked cycle by cycle against a queue-based reference model.
module tb_uart_frame_packer;

  localparam int FB = 9;
  localparam int TO = 16;
  localparam int FW = 8 * FB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic [7:0]    s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [FW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          terr;
  logic [15:0]   drop;

  logic [7:0]    sat_s_tdata;
  logic          sat_s_tvalid;
  logic          sat_s_tready;
  logic [FW-1:0] sat_m_tdata;
  logic          sat_m_tvalid;
  logic          sat_m_tready;
  logic          sat_terr;
  logic [15:0]   sat_drop;

  uart_frame_packer #(.FRAME_BYTES(FB), .TIMEOUT_CYCLES(TO)) dut (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .timeout_err(terr), .drop_cnt(drop)
  );

  uart_frame_packer #(.FRAME_BYTES(FB), .TIMEOUT_CYCLES(2)) dut_sat (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(sat_s_tdata), .s_axis_tvalid(sat_s_tvalid), .s_axis_tready(sat_s_tready),
    .m_axis_tdata(sat_m_tdata), .m_axis_tvalid(sat_m_tvalid), .m_axis_tready(sat_m_tready),
    .timeout_err(sat_terr), .drop_cnt(sat_drop)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: bytes of the partial frame, a held frame, idle count.
  logic [7:0]    part_q[$];
  bit            holding;
  logic [FW-1:0] frame_m;
  int            idle;
  bit            terr_m;
  int            drops_m;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    part_q.delete();
    holding = 1'b0;
    frame_m = '0;
    idle    = 0;
    terr_m  = 1'b0;
    drops_m = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic mr);
    terr_m = 1'b0;
    if (holding) begin
      if (mr) begin
        holding = 1'b0;
        frame_m = '0;
      end
    end else if (v) begin
      part_q.push_back(d);
      idle = 0;
      if (part_q.size() == FB) begin
        frame_m = '0;
        for (int i = 0; i < FB; i++) frame_m[FW-8-8*i +: 8] = part_q[i];
        holding = 1'b1;
        part_q.delete();
      end
    end else if (part_q.size() > 0) begin
      idle++;
      if (idle == TO) begin
        part_q.delete();
        idle   = 0;
        terr_m = 1'b1;
        if (drops_m < 65535) drops_m++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("s_tready", 72'(s_tready), 72'(!holding));
    chk("m_tvalid", 72'(m_tvalid), 72'(holding));
    chk("m_tdata", 72'(m_tdata), 72'(frame_m));
    chk("timeout_err", 72'(terr), 72'(terr_m));
    chk("drop_cnt", 72'(drop), 72'(drops_m));
  endtask

  // One clock cycle: drive, check current outputs, clock, advance the model.
  task automatic cyc(input logic v, input logic [7:0] d, input logic mr);
    s_tvalid = v;
    s_tdata  = d;
    m_tready = mr;
    check_outputs();
    @(posedge clk);
    model_step(v, d, mr);
    #1;
  endtask

  logic [7:0] nom [FB];
  int exp_sat;

  initial begin
    nom = '{8'h80, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    areset = 1'b1;
    s_tvalid = 1'b0; s_tdata = 8'd0; m_tready = 1'b0;
    sat_s_tvalid = 1'b0; sat_s_tdata = 8'd0; sat_m_tready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    chk("rst_s_tready", 72'(s_tready), 72'd1);
    chk("rst_m_tdata", 72'(m_tdata), 72'd0);
    chk("rst_m_tvalid", 72'(m_tvalid), 72'd0);
    chk("rst_timeout_err", 72'(terr), 72'd0);
    chk("rst_drop_cnt", 72'(drop), 72'd0);
    chk("rst_sat_s_tready", 72'(sat_s_tready), 72'd1);
    chk("rst_sat_m_tdata", 72'(sat_m_tdata), 72'd0);
    chk("rst_sat_m_tvalid", 72'(sat_m_tvalid), 72'd0);
    @(negedge clk) areset = 1'b0;
    @(posedge clk);
    #1;

    // Nominal frame, back to back
    for (int i = 0; i < FB; i++) cyc(1'b1, nom[i], 1'b1);
    chk("nominal_frame", 72'(m_tdata), 72'h80_1122_3344_DEAD_BEEF);
    chk("nominal_tvalid", 72'(m_tvalid), 72'd1);
    chk("nominal_tready_low", 72'(s_tready), 72'd0);
    cyc(1'b0, 8'd0, 1'b1);
    chk("nominal_tready_back", 72'(s_tready), 72'd1);
    chk("nominal_tvalid_one_cycle", 72'(m_tvalid), 72'd0);
    cyc(1'b0, 8'd0, 1'b1);

    // Downstream stall with the source still presenting bytes
    for (int i = 0; i < FB; i++) cyc(1'b1, 8'($urandom), 1'b0);
    repeat (20) cyc(1'b1, 8'($urandom), 1'b0);
    cyc(1'b1, 8'($urandom), 1'b1);
    cyc(1'b1, 8'hA5, 1'b1);
    for (int i = 1; i < FB; i++) cyc(1'b1, 8'($urandom), 1'b1);
    chk("stall_next_byte0", 72'(m_tdata[FW-1:FW-8]), 72'hA5);
    cyc(1'b0, 8'd0, 1'b1);

    // Timeout discards a partial frame
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom), 1'b1);
    repeat (20) cyc(1'b0, 8'd0, 1'b1);
    chk("timeout_drop_one", 72'(drop), 72'd1);
    for (int i = 0; i < FB; i++) cyc(1'b1, nom[i], 1'b1);
    chk("timeout_new_frame", 72'(m_tdata), 72'h80_1122_3344_DEAD_BEEF);
    cyc(1'b0, 8'd0, 1'b1);

    // Byte arriving on the expiry cycle wins over the timeout
    cyc(1'b1, 8'($urandom), 1'b1);
    repeat (TO - 1) cyc(1'b0, 8'd0, 1'b1);
    chk("race_no_err_before", 72'(terr), 72'd0);
    cyc(1'b1, 8'($urandom), 1'b1);
    chk("race_no_err", 72'(terr), 72'd0);
    chk("race_drop_unchanged", 72'(drop), 72'd1);
    for (int i = 2; i < FB; i++) cyc(1'b1, 8'($urandom), 1'b1);
    chk("race_frame_done", 72'(m_tvalid), 72'd1);
    cyc(1'b0, 8'd0, 1'b1);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom), 1'b1);
    s_tvalid = 1'b0;
    #2 areset = 1'b1;
    #1;
    chk("amid_s_tready", 72'(s_tready), 72'd1);
    chk("amid_m_tdata", 72'(m_tdata), 72'd0);
    chk("amid_m_tvalid", 72'(m_tvalid), 72'd0);
    chk("amid_timeout_err", 72'(terr), 72'd0);
    chk("amid_drop_cnt", 72'(drop), 72'd0);
    model_reset();
    @(negedge clk) areset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < FB; i++) cyc(1'b1, nom[FB-1-i], 1'b1);
    chk("after_reset_frame", 72'(m_tdata), 72'hEF_BEAD_DE44_3322_1180);
    cyc(1'b0, 8'd0, 1'b1);
    chk("after_reset_drop", 72'(drop), 72'd0);

    // Randomized traffic with occasional long idle gaps
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        int gap;
        gap = int'($urandom_range(TO + 1, TO + 4));
        for (int g = 0; g < gap; g++) cyc(1'b0, 8'd0, 1'($urandom_range(0, 1)));
      end else begin
        cyc(1'(r < 60), 8'($urandom), 1'($urandom_range(0, 3) != 0));
      end
    end

    // Saturation of the drop counter, one stray byte per discard
    exp_sat = 0;
    for (int i = 0; i < 65537; i++) begin
      sat_s_tvalid = 1'b1;
      sat_s_tdata  = 8'(i);
      @(posedge clk);
      #1;
      sat_s_tvalid = 1'b0;
      chk("sat_err_low", 72'(sat_terr), 72'd0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      exp_sat = (exp_sat < 65535) ? exp_sat + 1 : 65535;
      chk("sat_err_pulse", 72'(sat_terr), 72'd1);
      chk("sat_drop_cnt", 72'(sat_drop), 72'(exp_sat));
    end
    chk("sat_final", 72'(sat_drop), 72'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
